// File: rtl/id_stage_pipe_pkg.sv
// Shared RV32I decode constants, immediate formats and operand selectors for id_stage_pipe.
package id_stage_pipe_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_fmt_e;

  typedef enum logic [1:0] {
    OP1_ZERO, OP1_RS1, OP1_PC
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_ZERO, OP2_RS2, OP2_IMM, OP2_FOUR
  } op2_sel_e;

  // Register-register ops: base funct7 always, alternate funct7 only for SUB and SRA.
  function automatic logic op_funct_legal(input logic [2:0] f3, input logic [6:0] f7);
    return (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SR)));
  endfunction

  function automatic logic shift_imm_legal(input logic [2:0] f3, input logic [6:0] f7);
    return !((f3 == F3_SLL) || (f3 == F3_SR)) || (f7 == F7_BASE) || (f7 == F7_ALT);
  endfunction

endpackage

// File: rtl/id_stage_pipe_imm_gen.sv
// Immediate extraction for the RV32I I/S/B/U/J formats, sign-extended to XLEN.
module imm_gen
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage with valid/ready output register, flush and load-use interlock.
// Optional macro ID_WB_BYPASS_EN adds a write-back forwarding port onto the operand reads.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int HAZARD_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [31:0]     in_instr,
  output logic [RA_W-1:0] rs1_addr,
  output logic [RA_W-1:0] rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
`ifdef ID_WB_BYPASS_EN
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
`endif
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_addr,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_store_data,
  output logic [RA_W-1:0] out_rd,
  output logic            out_reg_we,
  output logic            out_mem_we,
  output logic            out_mem_re,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_opcode
);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [31:0]     instr;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] store_data;
    logic [RA_W-1:0] rd;
    logic            reg_we;
    logic            mem_we;
    logic            mem_re;
    logic            branch;
    logic            jump;
    logic            illegal;
    logic [2:0]      func3;
    logic [6:0]      opcode;
  } out_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd_f;

  assign opcode = in_instr[6:0];
  assign rd_f   = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  imm_fmt_e        fmt;
  op1_sel_e        op1_sel;
  op2_sel_e        op2_sel;
  logic            sd_rs1, sd_rs2;
  logic            uses_rs1, uses_rs2;
  logic            reg_we, mem_we, mem_re, branch, jump, illegal;
  logic [XLEN-1:0] imm;

  always_comb begin
    fmt      = IMM_NONE;
    op1_sel  = OP1_ZERO;
    op2_sel  = OP2_ZERO;
    sd_rs1   = 1'b0;
    sd_rs2   = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        fmt = IMM_U; op2_sel = OP2_IMM; reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        fmt = IMM_U; op1_sel = OP1_PC; op2_sel = OP2_IMM; reg_we = 1'b1;
      end
      OPC_JAL: begin
        fmt = IMM_J; op1_sel = OP1_PC; op2_sel = OP2_FOUR; jump = 1'b1; reg_we = 1'b1;
      end
      OPC_JALR: begin
        fmt = IMM_I; op1_sel = OP1_PC; op2_sel = OP2_FOUR; sd_rs1 = 1'b1;
        uses_rs1 = 1'b1; jump = 1'b1; reg_we = 1'b1;
      end
      OPC_BRANCH: begin
        fmt = IMM_B; op1_sel = OP1_RS1; op2_sel = OP2_RS2;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; branch = 1'b1;
        illegal = (f3 == F3_SLT) || (f3 == F3_SLTU);
      end
      OPC_LOAD: begin
        fmt = IMM_I; op1_sel = OP1_RS1; op2_sel = OP2_IMM;
        uses_rs1 = 1'b1; mem_re = 1'b1; reg_we = 1'b1;
        illegal = (f3 == F3_SLTU) || (f3 == F3_OR) || (f3 == F3_AND);
      end
      OPC_STORE: begin
        fmt = IMM_S; op1_sel = OP1_RS1; op2_sel = OP2_IMM; sd_rs2 = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; mem_we = 1'b1;
        illegal = (f3 >= F3_SLTU);
      end
      OPC_OP_IMM: begin
        fmt = IMM_I; op1_sel = OP1_RS1; op2_sel = OP2_IMM;
        uses_rs1 = 1'b1; reg_we = 1'b1;
        illegal = !shift_imm_legal(f3, f7);
      end
      OPC_OP: begin
        op1_sel = OP1_RS1; op2_sel = OP2_RS2;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; reg_we = 1'b1;
        illegal = !op_funct_legal(f3, f7);
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
    // Illegal words still flow down the pipe but must not cause side effects.
    if (illegal) begin
      reg_we = 1'b0; mem_we = 1'b0; mem_re = 1'b0; branch = 1'b0; jump = 1'b0;
    end
    if (rd_f == 5'd0) reg_we = 1'b0;
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

  assign rs1_addr = uses_rs1 ? RA_W'(in_instr[19:15]) : '0;
  assign rs2_addr = uses_rs2 ? RA_W'(in_instr[24:20]) : '0;

  logic [XLEN-1:0] rs1_val, rs2_val;

`ifdef ID_WB_BYPASS_EN
  assign rs1_val = (wb_we && (wb_rd != '0) && (wb_rd == rs1_addr)) ? wb_data : rs1_data;
  assign rs2_val = (wb_we && (wb_rd != '0) && (wb_rd == rs2_addr)) ? wb_data : rs2_data;
`else
  assign rs1_val = rs1_data;
  assign rs2_val = rs2_data;
`endif

  out_t dec;
  out_t out_d, out_q;
  logic out_valid_d, out_valid_q;
  logic hazard, adv, load;

  always_comb begin
    dec        = '0;
    dec.addr   = in_addr;
    dec.instr  = in_instr;
    dec.imm    = imm;
    dec.rd     = reg_we ? RA_W'(rd_f) : '0;
    dec.reg_we = reg_we;
    dec.mem_we = mem_we;
    dec.mem_re = mem_re;
    dec.branch = branch;
    dec.jump   = jump;
    dec.illegal = illegal;
    dec.func3  = f3;
    dec.opcode = opcode;
    case (op1_sel)
      OP1_RS1: dec.op1 = rs1_val;
      OP1_PC:  dec.op1 = in_addr;
      default: dec.op1 = '0;
    endcase
    case (op2_sel)
      OP2_RS2:  dec.op2 = rs2_val;
      OP2_IMM:  dec.op2 = imm;
      OP2_FOUR: dec.op2 = XLEN'(4);
      default:  dec.op2 = '0;
    endcase
    dec.store_data = sd_rs1 ? rs1_val : (sd_rs2 ? rs2_val : '0);
  end

  generate
    if (HAZARD_EN != 0) begin : g_hazard
      assign hazard = out_valid_q && out_q.mem_re && (out_q.rd != '0) &&
                      ((uses_rs1 && (rs1_addr == out_q.rd)) ||
                       (uses_rs2 && (rs2_addr == out_q.rd)));
    end else begin : g_no_hazard
      assign hazard = 1'b0;
    end
  endgenerate

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && !hazard && !flush;
  assign load     = in_valid && in_ready;

  // Flush implies !load, so it only has to open the valid update.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (adv || flush) out_valid_d = load;
    if (load) out_d = dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_addr       = out_q.addr;
  assign out_instr      = out_q.instr;
  assign out_op1        = out_q.op1;
  assign out_op2        = out_q.op2;
  assign out_imm        = out_q.imm;
  assign out_store_data = out_q.store_data;
  assign out_rd         = out_q.rd;
  assign out_reg_we     = out_q.reg_we;
  assign out_mem_we     = out_q.mem_we;
  assign out_mem_re     = out_q.mem_re;
  assign out_branch     = out_q.branch;
  assign out_jump       = out_q.jump;
  assign out_illegal    = out_q.illegal;
  assign out_func3      = out_q.func3;
  assign out_opcode     = out_q.opcode;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode vector table plus interlock, stall, flush and reset sequences.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_instr;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] out_addr, out_instr, out_op1, out_op2, out_imm, out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_we, out_mem_we, out_mem_re, out_branch, out_jump, out_illegal;
  logic [2:0]  out_func3;
  logic [6:0]  out_opcode;
`ifdef ID_WB_BYPASS_EN
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
`endif

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .RA_W(5), .HAZARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_instr(in_instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef ID_WB_BYPASS_EN
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr), .out_op1(out_op1), .out_op2(out_op2),
    .out_imm(out_imm), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_we(out_reg_we), .out_mem_we(out_mem_we), .out_mem_re(out_mem_re),
    .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal),
    .out_func3(out_func3), .out_opcode(out_opcode)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ctrl = {reg_we, mem_we, mem_re, branch, jump, illegal}
  typedef struct {
    logic [31:0] instr, pc, r1, r2, op1, op2, imm, sd;
    logic [4:0]  rd, rs1a, rs2a;
    logic [5:0]  ctrl;
  } vec_t;

  localparam logic [31:0] R1 = 32'h1111_1111;
  localparam logic [31:0] R2 = 32'h2222_2222;

  vec_t vecs[15];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'hFFB00093, 32'h000, 32'h0, R2, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h0, 5'd1, 5'd0, 5'd0, 6'b100000}; // addi x1,x0,-5
    vecs[1]  = '{32'h001000EF, 32'h100, R1, R2, 32'h100, 32'h4, 32'h800, 32'h0, 5'd1, 5'd0, 5'd0, 6'b100010};           // jal x1,+2048
    vecs[2]  = '{32'hFE208EE3, 32'h104, R1, R2, R1, R2, 32'hFFFFFFFC, 32'h0, 5'd0, 5'd1, 5'd2, 6'b000100};              // beq x1,x2,-4
    vecs[3]  = '{32'h123451B7, 32'h108, R1, R2, 32'h0, 32'h12345000, 32'h12345000, 32'h0, 5'd3, 5'd0, 5'd0, 6'b100000}; // lui
    vecs[4]  = '{32'hFFFFF217, 32'h200, R1, R2, 32'h200, 32'hFFFFF000, 32'hFFFFF000, 32'h0, 5'd4, 5'd0, 5'd0, 6'b100000}; // auipc
    vecs[5]  = '{32'h0020A423, 32'h204, R1, R2, R1, 32'h8, 32'h8, R2, 5'd0, 5'd1, 5'd2, 6'b010000};                    // sw x2,8(x1)
    vecs[6]  = '{32'h00412283, 32'h208, R1, R2, R1, 32'h4, 32'h4, 32'h0, 5'd5, 5'd2, 5'd0, 6'b101000};                 // lw x5,4(x2)
    vecs[7]  = '{32'h409403B3, 32'h20C, R1, R2, R1, R2, 32'h0, 32'h0, 5'd7, 5'd8, 5'd9, 6'b100000};                    // sub x7,x8,x9
    vecs[8]  = '{32'h010280E7, 32'h300, R1, R2, 32'h300, 32'h4, 32'h10, R1, 5'd1, 5'd5, 5'd0, 6'b100010};              // jalr x1,16(x5)
    vecs[9]  = '{32'h0000007F, 32'h304, R1, R2, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 6'b000001};              // bad opcode
    vecs[10] = '{32'h409463B3, 32'h308, R1, R2, R1, R2, 32'h0, 32'h0, 5'd0, 5'd8, 5'd9, 6'b000001};                    // or with alt funct7
    vecs[11] = '{32'h00208033, 32'h30C, R1, R2, R1, R2, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2, 6'b000000};                    // add x0,x1,x2
    vecs[12] = '{32'hFE20AEE3, 32'h310, R1, R2, R1, R2, 32'hFFFFFFFC, 32'h0, 5'd0, 5'd1, 5'd2, 6'b000001};             // branch funct3 010
    vecs[13] = '{32'h02309093, 32'h314, R1, R2, R1, 32'h23, 32'h23, 32'h0, 5'd0, 5'd1, 5'd0, 6'b000001};              // slli bad funct7
    vecs[14] = '{32'h0000000F, 32'h318, R1, R2, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 6'b000000};              // fence

    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_instr = '0;
    rs1_data = '0; rs2_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_instr", out_instr, 32'h0);
    chk("reset_op2", out_op2, 32'h0);
    chk("reset_ctrl", 32'({out_reg_we, out_mem_we, out_mem_re, out_branch, out_jump, out_illegal, out_rd}), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = vecs[i].instr; in_addr = vecs[i].pc;
      rs1_data = vecs[i].r1; rs2_data = vecs[i].r2;
      #1;
      chk($sformatf("v%0d_rs1_addr", i), 32'(rs1_addr), 32'(vecs[i].rs1a));
      chk($sformatf("v%0d_rs2_addr", i), 32'(rs2_addr), 32'(vecs[i].rs2a));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("v%0d_instr", i), out_instr, vecs[i].instr);
      chk($sformatf("v%0d_op1", i), out_op1, vecs[i].op1);
      chk($sformatf("v%0d_op2", i), out_op2, vecs[i].op2);
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d_store_data", i), out_store_data, vecs[i].sd);
      chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_ctrl", i),
          32'({out_reg_we, out_mem_we, out_mem_re, out_branch, out_jump, out_illegal}), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d_func3_opcode", i), 32'({out_func3, out_opcode}),
          32'({vecs[i].instr[14:12], vecs[i].instr[6:0]}));
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_bubble_valid", 32'(out_valid), 32'h0);

    // Load-use: lw x5,0(x2) followed by add x6,x5,x1
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00012283; in_addr = 32'h400;
    @(posedge clk); #1;
    chk("lu_load_valid", 32'(out_valid), 32'h1);
    @(negedge clk);
    in_instr = 32'h00128333; in_addr = 32'h404;
    #1;
    chk("lu_hazard_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("lu_bubble_valid", 32'(out_valid), 32'h0);
    @(negedge clk); #1;
    chk("lu_release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("lu_add_valid", 32'(out_valid), 32'h1);
    chk("lu_add_instr", out_instr, 32'h00128333);
    chk("lu_add_rd", 32'(out_rd), 32'h6);

    // Stall: register FULL with addi, out_ready low for 3 cycles while in_valid toggles
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hFFB00093; in_addr = 32'h500;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b0; in_instr = 32'h123451B7; in_addr = 32'h504; in_valid = (k != 1);
      #1;
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'h1);
      chk($sformatf("stall%0d_instr", k), out_instr, 32'hFFB00093);
      chk($sformatf("stall%0d_op2", k), out_op2, 32'hFFFFFFFB);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    #1;
    chk("stall_release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("stall_release_instr", out_instr, 32'h123451B7);
    chk("stall_release_valid", 32'(out_valid), 32'h1);

    // Flush with FULL register and an incoming store
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0020A423; in_addr = 32'h600;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_hold_instr", out_instr, 32'h123451B7);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush_dropped_valid", 32'(out_valid), 32'h0);

    // Asynchronous reset in the middle of a stall
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hFFB00093; in_addr = 32'h700;
    @(posedge clk);
    @(negedge clk) out_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'h0);
    chk("async_reset_instr", out_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_valid", 32'(out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised RV32I decode stage. Sits between the IF/ID latch and EX.
- Decodes the full RV32I base opcode set into operands, immediate and control signals.
- Holds results in an output pipeline register with a valid/ready handshake, plus flush and a load-use interlock.
- Replaces the combinational ADDI/ADD/OR/AND/L/S/B-only decoder.

Parameters:
- XLEN, 32, datapath width; immediates sign-extend to XLEN.
- RA_W, 5, register-address width.
- HAZARD_EN, 1, when 1 the load-use interlock is active; when 0, hazard is tied to 0.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  decode accepts in_instr this cycle
in_addr  in  XLEN  instruction PC
in_instr  in  32  instruction word
rs1_addr  out  RA_W  regfile read address 1 (combinational from in_instr)
rs2_addr  out  RA_W  regfile read address 2 (combinational)
rs1_data  in  XLEN  regfile read data 1
rs2_data  in  XLEN  regfile read data 2
flush  in  1  kill the registered and incoming instruction (branch taken)
out_valid  out  1  output register holds a live instruction
out_ready  in  1  EX consumes this cycle
out_addr, out_instr  out  XLEN/32  passed through
out_op1, out_op2  out  XLEN  ALU operands
out_imm  out  XLEN  decoded immediate
out_store_data  out  XLEN  rs2 value for stores
out_rd  out  RA_W  destination register (0 if none)
out_reg_we, out_mem_we, out_mem_re, out_branch, out_jump, out_illegal  out  1  control
out_func3  out  3  funct3
out_opcode  out  7  opcode

Behaviour:
- Reset: out_valid=0; every registered output=0.
- rs1_addr/rs2_addr/in_ready are combinational and not reset.
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
  - Load condition: load = in_valid & in_ready.
  - Advance condition: adv = !out_valid | out_ready.
  - in_ready = adv & !hazard & !flush.
- On adv:
  - If load: the register takes the decoded instruction; out_valid=1.
  - Otherwise: out_valid=0 (bubble); the other fields hold their values.
- When !adv: all outputs hold, including under in_valid toggling.
- Latency: one cycle from accept to out_valid.
- Hazard: out_valid & out_mem_re & out_rd!=0 & ((uses_rs1 & rs1==out_rd) | (uses_rs2 & rs2==out_rd)).
  - A bubble is inserted exactly once.
  - The next cycle the load has left and the instruction is accepted.
- flush: next edge forces out_valid=0 and drops in_instr (in_ready=0). Flush has priority over hazard and load.
- Decode (imm per RV32I I/S/B/U/J formats, sign-extended):
  - LUI: op1=0, op2=imm, we.
  - AUIPC: op1=pc, op2=imm, we.
  - JAL: op1=pc, op2=4, imm=J, jump, we.
  - JALR: op1=pc, op2=4, imm=I, store_data=rs1, jump, we.
  - BRANCH: op1=rs1, op2=rs2, imm=B, branch. funct3 010/011 are illegal.
  - LOAD: op1=rs1, op2=imm, mem_re, we. funct3 011/110/111 are illegal.
  - STORE: op1=rs1, op2=imm, store_data=rs2, mem_we. funct3 >=011 is illegal.
  - OP-IMM: op1=rs1, op2=imm, we. For SLLI/SRLI/SRAI, funct7 other than 0000000/0100000 is illegal.
  - OP: op1=rs1, op2=rs2, we. funct7 other than 0000000, or 0100000 with funct3 other than 000/101, is illegal.
  - FENCE/SYSTEM: treated as NOP (no controls).
  - Any other opcode: out_illegal=1.
- Illegal instructions: all enables=0, out_valid still 1.
- rd=x0 forces out_reg_we=0 and out_rd=0.
- uses_rs1/uses_rs2 are from format only.
- Unused rsN_addr is driven 0.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- When defined:
  - Add ports wb_we (in 1), wb_rd (in RA_W) and wb_data (in XLEN).
  - If wb_we & wb_rd!=0 & wb_rd==rsN, operand N uses wb_data instead of rsN_data.
- When not defined: ports are absent and operands come from the regfile only.

Decomposition:
- Shared package/define file holds:
  - Opcode constants: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, FENCE, SYSTEM.
  - funct3/funct7 constants.
  - Immediate-format enum: I, S, B, U, J, NONE.
- One sub-module, imm_gen: combinational instr + format -> XLEN immediate.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093), out_ready=1 -> next cycle out_valid=1, op2=0xFFFFFFFB, rd=1, reg_we=1.
- LW x5,0(x2) then ADD x6,x5,x1 back-to-back -> in_ready=0 for 1 cycle, one bubble, ADD issued the following cycle.
- out_ready=0 for 3 cycles with FULL register -> outputs stable, in_ready=0; release -> next instruction loads.
- flush asserted with FULL register and in_valid=1 -> next cycle out_valid=0, incoming dropped.
- JAL x1,+2048 at pc=0x100 -> op1=0x100, op2=4, imm=0x800, jump=1; BEQ with imm -4 -> imm=0xFFFFFFFC, branch=1.
- Opcode 0x7F, plus SUB-encoding on OR (funct7=0100000, funct3=110) -> out_illegal=1, all enables 0; reset mid-stall -> out_valid=0 immediately.
